axi_read_control_fifo: RTL and testbench
========================================

Name: axi_read_control_fifo

Overview:
Read-side counterpart of the input-image write path. Serves AXI-Lite style 32-bit read requests by popping 24-bit RGB pixel words from a first-word-fall-through (FWFT) result FIFO. It re-packs 4 pixels (12 bytes) into 3 little-endian 32-bit words. It sits between the AXI slave read channel and the output/readback FIFO of the accelerator.

Parameters:
OUT_WIDTH, 512, frame width in pixels
OUT_HEIGHT, 256, frame height in pixels; OUT_WIDTH*OUT_HEIGHT must be a multiple of 4
AXI_BASE_ADDR, 0, byte base address of the readback window
AXI_ADDR_WIDTH, 32, AXI address width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
axi_rd_addr  input  AXI_ADDR_WIDTH  byte address of the request, sampled with axi_rd_req
axi_rd_req  input  1  one-cycle request strobe; honoured only while axi_rd_ready=1
axi_rd_ready  output  1  block idle, can accept a request
axi_rd_data  output  32  response word, held until next response
axi_rd_valid  output  1  one-cycle pulse, axi_rd_data valid
fifo_rd_data  input  24  FWFT head pixel {B2,B1,B0}, B0 = first byte
fifo_empty  input  1  FIFO empty
fifo_rd_en  output  1  pop strobe, asserted only when fifo_empty=0
last_pixel  output  1  pulse coincident with pop of pixel OUT_WIDTH*OUT_HEIGHT-1

Behaviour:
- Reset and clocking: clk and rst_n, asynchronous active-low reset.
- Reset values:
  - axi_rd_ready=1, axi_rd_valid=0, axi_rd_data=0, fifo_rd_en=0, last_pixel=0.
  - State=IDLE, leftover count lc=0, pixel_cnt=0, leftover bytes buffer L0..L2 = 0.
  - Reset mid-operation aborts any pending request; no response is issued.
- Range check: in_range = addr>=AXI_BASE_ADDR && addr-AXI_BASE_ADDR < OUT_WIDTH*OUT_HEIGHT*3. Address bits beyond the range check are ignored; word order is strictly sequential.
- FSM states are IDLE, FILL, COMPLETE, RESP.
- IDLE: axi_rd_ready=1. On axi_rd_req:
  - Out of range: latch axi_rd_data=0, go to RESP. No pop.
  - In range, lc==0: go to FILL.
  - In range, lc!=0: go to COMPLETE.
- FILL: ready=0. If fifo_empty=0, pop the head pixel P into L0..L2 (L0=P.B0), then go to COMPLETE. Otherwise wait (stall, no timeout).
- COMPLETE: ready=0. If fifo_empty=0, pop the head pixel P and register axi_rd_data:
  - lc==0 (3 bytes buffered): word = {P.B0,L2,L1,L0}. Set L0=P.B1, L1=P.B2, lc=2.
  - lc==2: word = {P.B1,P.B0,L1,L0}. Set L0=P.B2, lc=1.
  - lc==1: word = {P.B2,P.B1,P.B0,L0}. Set lc=0.
  - Then go to RESP. Otherwise wait.
- RESP: axi_rd_valid=1 for exactly one cycle, ready=0. Next state is IDLE.
- Latency from the req cycle to the valid cycle, with the FIFO non-empty:
  - Out of range: 1 cycle.
  - lc!=0: 2 cycles.
  - lc==0: 3 cycles.
  - Each empty cycle adds 1.
- pixel_cnt: width clog2(W*H). Increments on every pop; wraps to 0 after W*H-1.
- Frame end: last_pixel pulses on the pop of pixel W*H-1. lc is forced to 0 on that pop (the leftover is discarded; it is 0 by construction when W*H%4==0).
- Requests while ready=0 are ignored (no queuing).
- fifo_rd_en is combinational: (state==FILL or COMPLETE) && !fifo_empty. Never more than one pop per cycle.

Test Plan:
- Pack sequence: FIFO holds 0x030201, 0x060504, 0x090807, 0x0C0B0A; 3 in-range reads -> words 0x04030201, 0x08070605, 0x0C0B0A09. 4 pops total; lc returns to 0; latencies 3, 2, 2 cycles.
- Out of range: read at AXI_BASE_ADDR+W*H*3 -> axi_rd_data=0 and valid 1 cycle after req. No fifo_rd_en; lc and pixel_cnt unchanged.
- Empty stall: FIFO empty for 5 cycles after req -> no valid, ready=0, fifo_rd_en=0. Pixel arrives -> response follows normally; data matches the pack-sequence word.
- Frame wrap (W=4, H=1): 3 reads -> last_pixel pulses on the 4th pop, pixel_cnt=0. A 4th read starts a new group with lc==0 (3-cycle latency).
- Req while busy: second axi_rd_req during FILL -> ignored; exactly one valid pulse and no extra pop.
- Reset mid-COMPLETE: assert rst_n=0 while stalled -> all outputs return to reset values immediately. After release, the first read behaves as lc==0.

Source files
------------

// File: rtl/axi_read_control_fifo.sv
// axi_read_control_fifo: serves 32-bit AXI-Lite reads by re-packing
// 24-bit pixels popped from an FWFT result FIFO into little-endian words.
module axi_read_control_fifo #(
   parameter int              OUT_WIDTH      = 512,
   parameter int              OUT_HEIGHT     = 256,
   parameter longint unsigned AXI_BASE_ADDR  = 0,
   parameter int              AXI_ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr,
   input  logic                      axi_rd_req,
   output logic                      axi_rd_ready,
   output logic [31:0]               axi_rd_data,
   output logic                      axi_rd_valid,
   input  logic [23:0]               fifo_rd_data,
   input  logic                      fifo_empty,
   output logic                      fifo_rd_en,
   output logic                      last_pixel
);

   localparam int NPIX = OUT_WIDTH * OUT_HEIGHT;
   localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [63:0] SPAN = 64'(NPIX) * 64'd3;
   localparam logic [AXI_ADDR_WIDTH-1:0] BASE =
      AXI_ADDR_WIDTH'(AXI_BASE_ADDR);
   localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_COMPLETE,
      S_RESP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [1:0]                r_lc;
   logic [CW-1:0]             r_pix_cnt;
   logic [7:0]                r_l0;
   logic [7:0]                r_l1;
   logic [7:0]                r_l2;
   logic [31:0]               r_data;
   logic                      w_pop;
   logic                      w_last;
   logic                      w_in_range;
   logic                      w_oor_req;
   logic [AXI_ADDR_WIDTH-1:0] w_off;
   logic [7:0]                w_b0;
   logic [7:0]                w_b1;
   logic [7:0]                w_b2;

   assign w_b0 = fifo_rd_data[7:0];
   assign w_b1 = fifo_rd_data[15:8];
   assign w_b2 = fifo_rd_data[23:16];

   assign w_off      = axi_rd_addr - BASE;
   assign w_in_range = (axi_rd_addr >= BASE) && (64'(w_off) < SPAN);
   assign w_oor_req  = (r_state == S_IDLE) && axi_rd_req && !w_in_range;

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (axi_rd_req) begin
               if (!w_in_range)    w_next = S_RESP;
               else if (r_lc == 0) w_next = S_FILL;
               else                w_next = S_COMPLETE;
            end
         end
         S_FILL: begin
            if (!fifo_empty) begin
               w_pop  = 1'b1;
               w_next = S_COMPLETE;
            end
         end
         S_COMPLETE: begin
            if (!fifo_empty) begin
               w_pop  = 1'b1;
               w_next = S_RESP;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_last       = w_pop && (r_pix_cnt == LAST_IDX);
   assign axi_rd_ready = (r_state == S_IDLE);
   assign axi_rd_valid = (r_state == S_RESP);
   assign axi_rd_data  = r_data;
   assign fifo_rd_en   = w_pop;
   assign last_pixel   = w_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lc      <= '0;
         r_pix_cnt <= '0;
         r_l0      <= '0;
         r_l1      <= '0;
         r_l2      <= '0;
         r_data    <= '0;
      end else begin
         if (w_oor_req) r_data <= '0;
         if (w_pop) r_pix_cnt <= w_last ? '0 : r_pix_cnt + CW'(1);
         if ((r_state == S_FILL) && w_pop) begin
            r_l0 <= w_b0;
            r_l1 <= w_b1;
            r_l2 <= w_b2;
         end
         // lc counts leftover bytes still held after the word just sent
         if ((r_state == S_COMPLETE) && w_pop) begin
            case (r_lc)
               2'd0: begin
                  r_data <= {w_b0, r_l2, r_l1, r_l0};
                  r_l0   <= w_b1;
                  r_l1   <= w_b2;
                  r_lc   <= 2'd2;
               end
               2'd2: begin
                  r_data <= {w_b1, w_b0, r_l1, r_l0};
                  r_l0   <= w_b2;
                  r_lc   <= 2'd1;
               end
               default: begin
                  r_data <= {w_b2, w_b1, w_b0, r_l0};
                  r_lc   <= 2'd0;
               end
            endcase
         end
         if (w_last) r_lc <= 2'd0;
      end
   end

endmodule

// File: tb/tb_axi_read_control_fifo.sv
// tb_axi_read_control_fifo: random and directed reads against a
// byte-stream reference model, checked by a scoreboard monitor.
module tb_axi_read_control_fifo;

   localparam int          W    = 4;
   localparam int          H    = 2;
   localparam int          NPIX = W * H;
   localparam int          SPAN = NPIX * 3;
   localparam logic [31:0] BASE = 32'h100;
   localparam int          NREF = 1024;

   typedef struct {
      logic [31:0] w;
      int          lat;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] axi_rd_addr;
   logic        axi_rd_req;
   logic        axi_rd_ready;
   logic [31:0] axi_rd_data;
   logic        axi_rd_valid;
   logic [23:0] fdata;
   logic        fempty;
   logic        fifo_rd_en;
   logic        last_pixel;
   logic        stall;

   logic [23:0] ref_pix [NREF];
   logic [23:0] fq [$];
   logic [7:0]  bq [$];
   exp_t        exp_q [$];

   int checks    = 0;
   int fails     = 0;
   int cyc       = 0;
   int pix_idx   = 0;
   int pix_total = 0;
   int pop_req   = 0;
   int pop_done  = 0;
   int mi        = 0;
   int base_i    = 0;

   axi_read_control_fifo #(
      .OUT_WIDTH      (W),
      .OUT_HEIGHT     (H),
      .AXI_BASE_ADDR  (64'(BASE)),
      .AXI_ADDR_WIDTH (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .axi_rd_addr  (axi_rd_addr),
      .axi_rd_req   (axi_rd_req),
      .axi_rd_ready (axi_rd_ready),
      .axi_rd_data  (axi_rd_data),
      .axi_rd_valid (axi_rd_valid),
      .fifo_rd_data (fdata),
      .fifo_empty   (fempty),
      .fifo_rd_en   (fifo_rd_en),
      .last_pixel   (last_pixel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: pixels become a byte stream; a read takes 4 bytes.
   function automatic void model(input logic [31:0] a,
                                 output logic [31:0] w, output int np);
      logic [23:0] p;
      bit          lastp;
      w     = '0;
      np    = 0;
      lastp = 0;
      if (a < BASE || (a - BASE) >= 32'(SPAN)) return;
      while (bq.size() < 4) begin
         p = ref_pix[mi];
         bq.push_back(p[7:0]);
         bq.push_back(p[15:8]);
         bq.push_back(p[23:16]);
         if (((mi - base_i) % NPIX) == NPIX - 1) lastp = 1;
         mi++;
         np++;
      end
      for (int i = 0; i < 4; i++) w[8*i +: 8] = bq.pop_front();
      if (lastp) bq.delete();
   endfunction

   // FWFT source FIFO
   initial begin
      fempty = 1'b1;
      fdata  = '0;
      for (int i = 0; i < NREF; i++) ref_pix[i] = 24'($urandom);
      ref_pix[0] = 24'h030201;
      ref_pix[1] = 24'h060504;
      ref_pix[2] = 24'h090807;
      ref_pix[3] = 24'h0C0B0A;
      for (int i = 0; i < NREF; i++) fq.push_back(ref_pix[i]);
      forever begin
         @(posedge clk);
         #1;
         while (pop_done < pop_req) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pop_done++;
         end
         #2;
         fempty = stall || (fq.size() == 0);
         fdata  = (fq.size() > 0) ? fq[0] : '0;
      end
   end

   // Monitor and scoreboard
   initial begin
      exp_t e;
      logic exp_last;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pix_idx = 0;
         end else begin
            if (fifo_rd_en) begin
               checks++;
               if (fempty) begin
                  fails++;
                  $display("FAIL pop_when_empty: got rd_en=1 expected 0");
               end
               exp_last = ((pix_idx % NPIX) == NPIX - 1);
               checks++;
               if (last_pixel !== exp_last) begin
                  fails++;
                  $display("FAIL last_pixel idx %0d: got %b expected %b",
                           pix_idx, last_pixel, exp_last);
               end
               pix_idx++;
               pix_total++;
               pop_req++;
            end else if (last_pixel) begin
               checks++;
               fails++;
               $display("FAIL last_no_pop: got 1 expected 0");
            end
            if (axi_rd_valid) begin
               checks++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_valid: got data %h expected none",
                           axi_rd_data);
               end else begin
                  e = exp_q.pop_front();
                  if (axi_rd_data !== e.w) begin
                     fails++;
                     $display("FAIL rd_data: got %h expected %h",
                              axi_rd_data, e.w);
                  end
                  checks++;
                  if (cyc - e.cyc != e.lat) begin
                     fails++;
                     $display("FAIL latency: got %0d expected %0d",
                              cyc - e.cyc, e.lat);
                  end
               end
            end
         end
         cyc++;
      end
   end

   task automatic rd(input logic [31:0] a, input int k, input bit poke,
                     input bit use_w, input logic [31:0] ow);
      exp_t        e;
      int          np;
      int          n;
      logic [31:0] w;
      n = 0;
      while (!axi_rd_ready && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!axi_rd_ready) begin
         checks++;
         fails++;
         $display("FAIL ready_timeout: got ready=0 expected 1");
         return;
      end
      model(a, w, np);
      e.w   = use_w ? ow : w;
      e.lat = 1 + np + ((np > 0) ? k : 0);
      e.cyc = cyc;
      exp_q.push_back(e);
      axi_rd_addr = a;
      axi_rd_req  = 1'b1;
      stall       = (k > 0);
      @(posedge clk);
      #2;
      axi_rd_req = 1'b0;
      if (poke && k > 0) begin
         axi_rd_req  = 1'b1;
         axi_rd_addr = BASE;
      end
      for (int i = 0; i < k; i++) begin
         if (np > 0) begin
            chk("stall_ready", {31'd0, axi_rd_ready}, 32'd0);
            chk("stall_valid", {31'd0, axi_rd_valid}, 32'd0);
         end
         @(posedge clk);
         #2;
         axi_rd_req = 1'b0;
      end
      stall = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 300) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending expected 0",
                  exp_q.size());
      end
      repeat (2) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"}, {31'd0, axi_rd_ready}, 32'd1);
      chk({tag, "_valid"}, {31'd0, axi_rd_valid}, 32'd0);
      chk({tag, "_data"},  axi_rd_data,           32'd0);
      chk({tag, "_rden"},  {31'd0, fifo_rd_en},   32'd0);
      chk({tag, "_last"},  {31'd0, last_pixel},   32'd0);
   endtask

   initial begin
      int t0;
      rst_n       = 1'b0;
      axi_rd_addr = '0;
      axi_rd_req  = 1'b0;
      stall       = 1'b0;
      #1;
      chk_reset_outs("por");
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;

      rd(BASE,     0, 0, 1, 32'h04030201);
      rd(BASE + 4, 0, 0, 1, 32'h08070605);
      rd(BASE + 8, 0, 0, 1, 32'h0C0B0A09);
      drain();
      chk("pack_pops", 32'(pix_total), 32'd4);

      t0 = pix_total;
      rd(BASE + 32'(SPAN), 0, 0, 1, 32'd0);
      rd(BASE - 4,         0, 0, 1, 32'd0);
      drain();
      chk("oor_pops", 32'(pix_total), 32'(t0));

      rd(BASE, 5, 0, 0, '0);
      rd(BASE + 4, 0, 0, 0, '0);
      rd(BASE + 8, 0, 0, 0, '0);
      rd(BASE, 0, 0, 0, '0);
      rd(BASE + 4, 2, 1, 0, '0);
      drain();
      chk("pops_vs_model_a", 32'(pix_total), 32'(mi));

      if (bq.size() == 0) begin
         rd(BASE, 0, 0, 0, '0);
         drain();
      end
      stall       = 1'b1;
      axi_rd_addr = BASE;
      axi_rd_req  = 1'b1;
      @(posedge clk);
      #2;
      axi_rd_req = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      chk("pend_ready", {31'd0, axi_rd_ready}, 32'd0);
      chk("pend_rden",  {31'd0, fifo_rd_en},   32'd0);
      stall = 1'b0;
      rst_n = 1'b0;
      #2;
      chk_reset_outs("mid");
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      bq.delete();
      base_i = mi;
      rd(BASE, 0, 0, 0, '0);

      for (int t = 0; t < 150; t++) begin
         logic [31:0] a;
         int          k;
         bit          pk;
         if ($urandom_range(0, 99) < 85)
            a = BASE + 32'($urandom_range(0, SPAN / 4 - 1)) * 4;
         else if ($urandom_range(0, 1) == 1)
            a = BASE + 32'(SPAN) + 32'($urandom_range(0, 64));
         else
            a = BASE - 32'($urandom_range(1, 256));
         k  = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 4)) : 0;
         pk = (k > 0) && ($urandom_range(0, 1) == 1);
         rd(a, k, pk, 0, '0);
      end
      drain();
      chk("pops_vs_model_b", 32'(pix_total), 32'(mi));

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
